dm_resp: RTL

DM_RESP -- requirements
Module: dm_resp

---
 rtl/dm_pkg.sv | 14 +
 rtl/dm_wait_cnt.sv | 34 +++
 rtl/dm_resp.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared defaults and FSM state encoding for the data-memory responder.
package dm_pkg;

    localparam int unsigned DM_BIT_SIZE = 32;
    localparam int unsigned DM_MEM_SIZE = 16;
    localparam int unsigned DM_DEPTH    = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

endpackage

// File: rtl/dm_wait_cnt.sv
// Loadable 4-bit down-counter with zero flag; load wins over decrement.
// Decrement saturates at zero so an extra dec never wraps.
module dm_wait_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: request sampled in IDLE, WAIT_CYCLES wait states, one-cycle RESP pulse.
// DM_ADDR_CHECK_EN: out-of-range addresses raise DM_err and drop writes; otherwise addresses wrap.
module dm_resp
    import dm_pkg::*;
#(
    parameter int unsigned bit_size    = DM_BIT_SIZE,
    parameter int unsigned mem_size    = DM_MEM_SIZE,
    parameter int unsigned DEPTH       = DM_DEPTH,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                DM_req,
    input  logic [mem_size-1:0] DM_Address,
    input  logic                DM_enable,
    input  logic [bit_size-1:0] DM_Write_Data,
    output logic [bit_size-1:0] DM_Read_Data,
    output logic                DM_ready,
    output logic                DM_err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  LOAD_VAL = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [bit_size-1:0] DM_data [0:DEPTH-1];

    dm_state_e           state_q, state_d;
    logic [mem_size-1:0] addr_q, addr_d;
    logic                we_q, we_d;
    logic [bit_size-1:0] wdata_q, wdata_d;
    logic [bit_size-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                oob_d;
    logic [IDX_W-1:0]    idx_d;
    logic                cnt_load, cnt_dec, cnt_zero;

    dm_wait_cnt u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (DM_req) begin
                    addr_d   = DM_Address;
                    we_d     = DM_enable;
                    wdata_d  = DM_Write_Data;
                    cnt_load = 1'b1;
                    state_d  = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    state_d = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data and error are computed from the next-state view so that a
    // zero-wait access (IDLE straight to RESP) sees the freshly sampled address.
    assign idx_d = addr_d[IDX_W-1:0];
`ifdef DM_ADDR_CHECK_EN
    assign oob_d = (addr_d >= mem_size'(DEPTH));
`else
    logic addr_hi_unused;
    assign oob_d          = 1'b0;
    assign addr_hi_unused = ^addr_q[mem_size-1:IDX_W];
`endif
    assign rdata_d = ((state_d == RESP) && !we_d && !oob_d) ? DM_data[idx_d] : '0;
    assign err_d   = (state_d == RESP) && oob_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // err_q is only ever set during RESP, so it doubles as the write-drop qualifier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                DM_data[i] <= '0;
            end
        end else if ((state_q == RESP) && we_q && !err_q) begin
            DM_data[addr_q[IDX_W-1:0]] <= wdata_q;
        end
    end

    assign DM_Read_Data = rdata_q;
    assign DM_ready     = (state_q == RESP);
`ifdef DM_ADDR_CHECK_EN
    assign DM_err = err_q;
`else
    assign DM_err = 1'b0;
`endif

endmodule
